mem_stage: RTL

- Memory-access stage of the RV64 five-stage pipeline, directly downstream of the execute stage.
- Consumes the EX/MEM register contents: ALU result (effective address or plain result), forwarded store data, destination register and memory-op controls.
- Performs aligned loads and stores over a req/ack data bus, stalling upstream while the bus is busy.
- Drives the MEM/WB pipeline register and the `me_alu_result` forwarding path back into execute.

---
 rtl/mem_stage_if.sv | 20 ++
 rtl/mem_stage.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - data bus request/ack interface between mem_stage and memory
interface mem_stage_if;
    logic        dbus_req;
    logic        dbus_we;
    logic [63:0] dbus_addr;
    logic [63:0] dbus_wdata;
    logic [7:0]  dbus_wmask;
    logic        dbus_ack;
    logic [63:0] dbus_rdata;

    modport master (
        output dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_wmask,
        input  dbus_ack, dbus_rdata
    );

    modport slave (
        input  dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_wmask,
        output dbus_ack, dbus_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - RV64 memory-access stage: aligned loads/stores over req/ack bus
module mem_stage #(
    parameter int XLEN   = 64,
    parameter int DBUS_W = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic            mem_rd,
    input  logic            mem_wr,
    input  logic [1:0]      mem_size,
    input  logic            mem_unsigned,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] store_data,
    input  logic [4:0]      rd_addr,
    input  logic            rd_wen,
    output logic [XLEN-1:0] me_alu_result,
    output logic            mem_stall,
    output logic            misalign_exc,
    mem_stage_if.master     bus,
    output logic            wb_valid,
    output logic [4:0]      wb_rd_addr,
    output logic            wb_rd_wen,
    output logic [XLEN-1:0] wb_rd_data
);
    localparam int LANES = DBUS_W / 8;

    typedef enum logic {IDLE, BUSY} state_t;
    state_t state_q, state_d;

    logic [4:0]       lat_rd_addr;
    logic             lat_rd_wen;
    logic [2:0]       lat_off;
    logic [1:0]       lat_size;
    logic             lat_unsigned;
    logic             lat_rd;

    logic             access, aligned, accept, ack_done;
    logic [2:0]       off;
    logic [LANES-1:0] size_mask;
    logic [XLEN-1:0]  shifted, load_data;

    assign me_alu_result = alu_result;
    assign access        = ex_valid & (mem_rd | mem_wr);
    assign off           = alu_result[2:0];

    always_comb begin
        aligned   = 1'b1;
        size_mask = 8'h01;
        case (mem_size)
            2'd0: begin aligned = 1'b1;            size_mask = 8'h01; end
            2'd1: begin aligned = (off[0] == 1'b0);   size_mask = 8'h03; end
            2'd2: begin aligned = (off[1:0] == 2'b0); size_mask = 8'h0F; end
            default: begin aligned = (off == 3'b0);   size_mask = 8'hFF; end
        endcase
    end

    // Load data is right-justified from its byte lane, then extended to XLEN.
    always_comb begin
        shifted   = bus.dbus_rdata >> {lat_off, 3'b000};
        load_data = shifted;
        case (lat_size)
            2'd0: load_data = lat_unsigned ? {56'b0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
            2'd1: load_data = lat_unsigned ? {48'b0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
            2'd2: load_data = lat_unsigned ? {32'b0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
            default: load_data = shifted;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        mem_stall = 1'b0;
        accept    = 1'b0;
        ack_done  = 1'b0;
        case (state_q)
            IDLE: begin
                if (access && aligned) begin
                    mem_stall = 1'b1;
                    accept    = 1'b1;
                    state_d   = BUSY;
                end
            end
            default: begin
                mem_stall = ~bus.dbus_ack;
                if (bus.dbus_ack) begin
                    ack_done = 1'b1;
                    state_d  = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.dbus_req   <= 1'b0;
            bus.dbus_we    <= 1'b0;
            bus.dbus_addr  <= '0;
            bus.dbus_wdata <= '0;
            bus.dbus_wmask <= '0;
            misalign_exc   <= 1'b0;
            wb_valid       <= 1'b0;
            wb_rd_addr     <= '0;
            wb_rd_wen      <= 1'b0;
            wb_rd_data     <= '0;
            lat_rd_addr    <= '0;
            lat_rd_wen     <= 1'b0;
            lat_off        <= '0;
            lat_size       <= '0;
            lat_unsigned   <= 1'b0;
            lat_rd         <= 1'b0;
        end else begin
            misalign_exc <= 1'b0;
            if (state_q == IDLE) begin
                if (accept) begin
                    bus.dbus_req   <= 1'b1;
                    bus.dbus_we    <= mem_wr;
                    bus.dbus_addr  <= {alu_result[XLEN-1:3], 3'b000};
                    bus.dbus_wmask <= size_mask << off;
                    bus.dbus_wdata <= store_data << {off, 3'b000};
                    lat_rd_addr    <= rd_addr;
                    lat_rd_wen     <= rd_wen;
                    lat_off        <= off;
                    lat_size       <= mem_size;
                    lat_unsigned   <= mem_unsigned;
                    lat_rd         <= mem_rd;
                    wb_valid       <= 1'b0;
                    wb_rd_wen      <= 1'b0;
                end else if (access) begin
                    // Misaligned access is dropped; the slot retires without a write.
                    misalign_exc <= 1'b1;
                    wb_valid     <= 1'b1;
                    wb_rd_addr   <= rd_addr;
                    wb_rd_wen    <= 1'b0;
                    wb_rd_data   <= alu_result;
                end else begin
                    wb_valid   <= ex_valid;
                    wb_rd_addr <= rd_addr;
                    wb_rd_wen  <= rd_wen & ex_valid;
                    wb_rd_data <= alu_result;
                end
            end else if (ack_done) begin
                bus.dbus_req <= 1'b0;
                wb_valid     <= 1'b1;
                wb_rd_addr   <= lat_rd_addr;
                wb_rd_wen    <= lat_rd_wen & lat_rd;
                wb_rd_data   <= lat_rd ? load_data : '0;
            end else begin
                wb_valid  <= 1'b0;
                wb_rd_wen <= 1'b0;
            end
        end
    end
endmodule
